jtframe_ram_upload: RTL

Upload-direction counterpart of the ROM/NVRAM download path. It serves bytes requested by the io controller during a "Save NVRAM" upload session by reading 16-bit words from the SDRAM programming port and returning them on `ioctl_data_out`. A one-word cache and a next-word prefetch keep SDRAM traffic to one read per two bytes. It sits in the frame between the io-controller byte interface and the SDRAM arbiter's `prog_*` port, all in the `clk_rom` domain.

---
 rtl/jtframe_ram_upload.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jtframe_ram_upload.sv
// jtframe_ram_upload: serves NVRAM upload bytes to the io controller from SDRAM words, with a one-word cache and next-word prefetch
//   clk, rst                  : clock (clk_rom) and synchronous active-high reset
//   ioctl_ram, ioctl_addr,
//   ioctl_rd                  : upload session flag, byte address and one-cycle byte request
//   ioctl_data_out, ioctl_rdy : returned byte and its one-cycle valid pulse
//   busy                      : a demand request is outstanding
//   prog_addr, prog_rd,
//   prog_bank                 : SDRAM read request (level, held until sdram_ack)
//   sdram_ack, data_rdy,
//   data_read                 : SDRAM request accept, read-data strobe and read word
module jtframe_ram_upload #(
  parameter int AW   = 22,
  parameter int BASE = 0,
  parameter int SIZE = 1024,
  parameter int BANK = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ioctl_ram,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_data_out,
  output logic          ioctl_rdy,
  output logic          busy,
  output logic [AW-1:0] prog_addr,
  output logic          prog_rd,
  output logic [1:0]    prog_bank,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);
  localparam logic [AW-1:0] BASE_W = AW'(BASE);
  localparam logic [25:0]   SIZE_B = 26'(SIZE);
  localparam logic [25:0]   SIZE_W = 26'(SIZE / 2);
  localparam logic [1:0]    BANK_B = 2'(BANK);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PREQ, S_PWAIT} state_t;
  function automatic logic [AW-1:0] word_of(input logic [24:0] a);
    return BASE_W + AW'(a[24:1]);
  endfunction
  function automatic logic in_range(input logic [24:0] a);
    return {1'b0, a} < SIZE_B;
  endfunction
  function automatic logic next_ok(input logic [24:0] a);
    return ({2'b0, a[24:1]} + 26'd1) < SIZE_W;
  endfunction
  state_t         state_q, state_d;
  logic [7:0]     dout_q, dout_d;
  logic           rdy_q, rdy_d, busy_q, busy_d, prog_rd_q, prog_rd_d;
  logic [AW-1:0]  prog_addr_q, prog_addr_d, tag_q, tag_d;
  logic [1:0]     prog_bank_q, prog_bank_d;
  logic [15:0]    cdata_q, cdata_d;
  logic           valid_q, valid_d, pend_q, pend_d, pref_q, pref_d, abort_q, abort_d;
  logic [24:0]    req_addr_q, req_addr_d;
  logic           take, is_pref, acking, got, serve, pend_now;
  logic [24:0]    srv_addr;
  logic [15:0]    srv_word;
  assign take    = ioctl_rd && ioctl_ram && !busy_q;
  assign is_pref = state_q == S_PREQ || state_q == S_PWAIT;
  assign acking  = (state_q == S_REQ || state_q == S_PREQ) && sdram_ack;
  // an ack and data_rdy in the same cycle complete the access at once
  assign got     = data_rdy && (acking || state_q == S_WAIT || state_q == S_PWAIT);
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    rdy_d       = 1'b0;
    busy_d      = busy_q;
    prog_rd_d   = prog_rd_q;
    prog_addr_d = prog_addr_q;
    tag_d       = tag_q;
    cdata_d     = cdata_q;
    valid_d     = valid_q & ioctl_ram;
    pend_d      = pend_q;
    pref_d      = pref_q & ioctl_ram;
    abort_d     = abort_q | ~ioctl_ram;
    req_addr_d  = req_addr_q;
    serve       = 1'b0;
    srv_addr    = ioctl_addr;
    srv_word    = cdata_q;
    pend_now    = 1'b0;
    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
      busy_d  = 1'b0;
      if (take) begin
        if (in_range(ioctl_addr) && !(valid_q && tag_q == word_of(ioctl_addr))) begin
          state_d     = S_REQ;
          prog_rd_d   = 1'b1;
          prog_addr_d = word_of(ioctl_addr);
          req_addr_d  = ioctl_addr;
          busy_d      = 1'b1;
          pref_d      = 1'b0;
        end else serve = 1'b1;
      end else if (pref_q && ioctl_ram) begin
        // the cache holds the word whose odd byte was just served
        state_d     = S_PREQ;
        prog_rd_d   = 1'b1;
        prog_addr_d = tag_q + AW'(1);
        pref_d      = 1'b0;
      end
    end else begin
      if (is_pref && take && !pend_q) begin
        pend_d     = 1'b1;
        req_addr_d = ioctl_addr;
        busy_d     = 1'b1;
      end
      pend_now = pend_d;
      if (acking) begin
        prog_rd_d = 1'b0;
        state_d   = state_q == S_REQ ? S_WAIT : S_PWAIT;
      end
      if (got) begin
        state_d  = S_IDLE;
        pend_d   = 1'b0;
        srv_addr = req_addr_d;
        srv_word = data_read;
        if (abort_d) busy_d = 1'b0;
        else begin
          tag_d   = prog_addr_q;
          cdata_d = data_read;
          valid_d = 1'b1;
          if (!is_pref || (pend_now && (!in_range(req_addr_d) || word_of(req_addr_d) == prog_addr_q)))
            serve = 1'b1;
          else if (pend_now) begin
            state_d     = S_REQ;
            prog_rd_d   = 1'b1;
            prog_addr_d = word_of(req_addr_d);
          end
        end
      end
    end
    if (serve) begin
      rdy_d  = 1'b1;
      dout_d = in_range(srv_addr) ? (srv_addr[0] ? srv_word[15:8] : srv_word[7:0]) : 8'hFF;
      pref_d = pref_d | (srv_addr[0] & next_ok(srv_addr));
    end
    prog_bank_d = prog_rd_d ? BANK_B : 2'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dout_q      <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      prog_rd_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_bank_q <= '0;
      tag_q       <= '0;
      cdata_q     <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      pref_q      <= 1'b0;
      abort_q     <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      prog_rd_q   <= prog_rd_d;
      prog_addr_q <= prog_addr_d;
      prog_bank_q <= prog_bank_d;
      tag_q       <= tag_d;
      cdata_q     <= cdata_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
      pref_q      <= pref_d;
      abort_q     <= abort_d;
      req_addr_q  <= req_addr_d;
    end
  end
  assign ioctl_data_out = dout_q;
  assign ioctl_rdy      = rdy_q;
  assign busy           = busy_q;
  assign prog_rd        = prog_rd_q;
  assign prog_addr      = prog_addr_q;
  assign prog_bank      = prog_bank_q;
endmodule
